// File: rtl/link_train_ctl.sv
// DisplayPort main-link training sequencer: drives the PHY pattern select
// through clock recovery and channel equalisation, polling sink status via AUX.
module link_train_ctl #(
  parameter int WAIT_CYC = 1000,
  parameter int CR_TRIES = 5,
  parameter int EQ_TRIES = 5
) (
  input  logic       dpclk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  output logic       poll_req,
  input  logic       poll_ack,
  input  logic       poll_cr,
  input  logic       poll_eq,
  output logic [1:0] phymode,
  output logic       busy,
  output logic       trained,
  output logic       failed,
  output logic [2:0] tries
);

  // state   | meaning
  // IDLE    | link off, phymode idle
  // CR_WAIT | sending TPS1, timer counting down to next poll
  // CR_POLL | TPS1, waiting for AUX to return CR status
  // EQ_WAIT | sending TPS2, timer counting down to next poll
  // EQ_POLL | TPS2, waiting for AUX to return CR/EQ status
  // ACTIVE  | scrambled video, link trained
  // FAIL    | training gave up; sticky until start/stop
  typedef enum logic [2:0] {
    IDLE, CR_WAIT, CR_POLL, EQ_WAIT, EQ_POLL, ACTIVE, FAIL
  } state_t;

  localparam int TW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(WAIT_CYC - 1);
  localparam logic [2:0] CR_LAST = 3'(CR_TRIES - 1);
  localparam logic [2:0] EQ_LAST = 3'(EQ_TRIES - 1);

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]    tries_nxt;
  logic [1:0]    phymode_nxt;
  logic          poll_req_nxt, busy_nxt, trained_nxt, failed_nxt;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    tries_nxt = tries;
    if (stop) begin
      state_nxt = IDLE;
      timer_nxt = '0;
      tries_nxt = '0;
    end else if (start) begin
      state_nxt = CR_WAIT;
      timer_nxt = RELOAD;
      tries_nxt = '0;
    end else begin
      case (state)
        CR_WAIT, EQ_WAIT: begin
          // leaving WAIT at zero keeps the timer frozen at 0 elsewhere
          if (timer == '0) state_nxt = (state == CR_WAIT) ? CR_POLL : EQ_POLL;
          else             timer_nxt = timer - TW'(1);
        end
        CR_POLL: begin
          if (poll_ack) begin
            if (poll_cr) begin
              state_nxt = EQ_WAIT;
              timer_nxt = RELOAD;
              tries_nxt = '0;
            end else begin
              tries_nxt = tries + 3'd1;
              if (tries == CR_LAST) begin
                state_nxt = FAIL;
              end else begin
                state_nxt = CR_WAIT;
                timer_nxt = RELOAD;
              end
            end
          end
        end
        EQ_POLL: begin
          if (poll_ack) begin
            if (!poll_cr) begin
              state_nxt = FAIL;
            end else if (poll_eq) begin
              state_nxt = ACTIVE;
              tries_nxt = '0;
            end else begin
              tries_nxt = tries + 3'd1;
              if (tries == EQ_LAST) begin
                state_nxt = FAIL;
              end else begin
                state_nxt = EQ_WAIT;
                timer_nxt = RELOAD;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    phymode_nxt  = 2'd0;
    poll_req_nxt = 1'b0;
    busy_nxt     = 1'b0;
    trained_nxt  = 1'b0;
    failed_nxt   = 1'b0;
    case (state_nxt)
      CR_WAIT: begin phymode_nxt = 2'd2; busy_nxt = 1'b1; end
      CR_POLL: begin phymode_nxt = 2'd2; busy_nxt = 1'b1; poll_req_nxt = 1'b1; end
      EQ_WAIT: begin phymode_nxt = 2'd3; busy_nxt = 1'b1; end
      EQ_POLL: begin phymode_nxt = 2'd3; busy_nxt = 1'b1; poll_req_nxt = 1'b1; end
      ACTIVE:  begin phymode_nxt = 2'd1; trained_nxt = 1'b1; end
      FAIL:    failed_nxt = 1'b1;
      default: ;
    endcase
  end

  // outputs are registered from the next-state decode so they track the state entered
  always_ff @(posedge dpclk) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      tries    <= '0;
      phymode  <= 2'd0;
      poll_req <= 1'b0;
      busy     <= 1'b0;
      trained  <= 1'b0;
      failed   <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      tries    <= tries_nxt;
      phymode  <= phymode_nxt;
      poll_req <= poll_req_nxt;
      busy     <= busy_nxt;
      trained  <= trained_nxt;
      failed   <= failed_nxt;
    end
  end

endmodule

// File: tb/tb_link_train_ctl.sv
// Bench for link_train_ctl: directed test-plan steps followed by random traffic,
// every cycle compared against a phase/countdown reference model.
module tb_link_train_ctl;

  localparam int WAIT = 4;
  localparam int CRT  = 3;
  localparam int EQT  = 3;

  localparam int P_IDLE = 0, P_CR = 1, P_EQ = 2, P_ACT = 3, P_FAIL = 4;

  logic       dpclk = 1'b0;
  logic       reset, start, stop, poll_ack, poll_cr, poll_eq;
  logic       poll_req, busy, trained, failed;
  logic [1:0] phymode;
  logic [2:0] tries;

  int tests = 0;
  int fails = 0;

  // reference model: training phase, pattern cycles left before the poll, poll outstanding
  int m_phase = P_IDLE;
  int m_cnt   = 0;
  int m_poll  = 0;
  int m_tries = 0;

  link_train_ctl #(.WAIT_CYC(WAIT), .CR_TRIES(CRT), .EQ_TRIES(EQT)) dut (
    .dpclk(dpclk), .reset(reset), .start(start), .stop(stop),
    .poll_req(poll_req), .poll_ack(poll_ack), .poll_cr(poll_cr), .poll_eq(poll_eq),
    .phymode(phymode), .busy(busy), .trained(trained), .failed(failed), .tries(tries)
  );

  always #5 dpclk = ~dpclk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit p, input bit a, input bit c, input bit e);
    if (r) begin
      m_phase = P_IDLE; m_poll = 0; m_tries = 0; m_cnt = 0;
    end else if (p) begin
      m_phase = P_IDLE; m_poll = 0; m_tries = 0;
    end else if (s) begin
      m_phase = P_CR; m_cnt = WAIT; m_poll = 0; m_tries = 0;
    end else if (m_poll != 0 && a) begin
      m_poll = 0;
      if (m_phase == P_CR) begin
        if (c) begin
          m_phase = P_EQ; m_cnt = WAIT; m_tries = 0;
        end else begin
          m_tries++;
          if (m_tries == CRT) m_phase = P_FAIL;
          else m_cnt = WAIT;
        end
      end else begin
        if (!c) m_phase = P_FAIL;
        else if (e) begin
          m_phase = P_ACT; m_tries = 0;
        end else begin
          m_tries++;
          if (m_tries == EQT) m_phase = P_FAIL;
          else m_cnt = WAIT;
        end
      end
    end else if ((m_phase == P_CR || m_phase == P_EQ) && m_poll == 0) begin
      m_cnt--;
      if (m_cnt == 0) m_poll = 1;
    end
  endtask

  function automatic logic [1:0] exp_mode();
    case (m_phase)
      P_CR:    return 2'd2;
      P_EQ:    return 2'd3;
      P_ACT:   return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  // one clock: drive inputs, step the model at the edge, compare all outputs 1 time unit later
  task automatic tick(input bit r, input bit s, input bit p, input bit a, input bit c, input bit e);
    reset = r; start = s; stop = p; poll_ack = a; poll_cr = c; poll_eq = e;
    @(posedge dpclk);
    model_step(r, s, p, a, c, e);
    #1;
    chk("m_phymode",  8'(phymode),  8'(exp_mode()));
    chk("m_poll_req", 8'(poll_req), 8'(m_poll));
    chk("m_busy",     8'(busy),     8'(m_phase == P_CR || m_phase == P_EQ));
    chk("m_trained",  8'(trained),  8'(m_phase == P_ACT));
    chk("m_failed",   8'(failed),   8'(m_phase == P_FAIL));
    chk("m_tries",    8'(tries),    8'(m_tries));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
  endtask

  task automatic ack(input bit c, input bit e);
    tick(0, 0, 0, 1, c, e);
  endtask

  initial begin
    reset = 1; start = 0; stop = 0; poll_ack = 0; poll_cr = 0; poll_eq = 0;
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    chk("rst_phymode", 8'(phymode), 8'd0);
    chk("rst_flags", 8'({poll_req, busy, trained, failed}), 8'd0);
    chk("rst_tries", 8'(tries), 8'd0);

    // happy path
    tick(0, 1, 0, 0, 0, 0);
    chk("start_phymode", 8'(phymode), 8'd2);
    chk("start_busy", 8'(busy), 8'd1);
    idle(WAIT - 1);
    chk("cr_poll_early", 8'(poll_req), 8'd0);
    idle(1);
    chk("cr_poll_rise", 8'(poll_req), 8'd1);
    ack(1, 0);
    chk("cr_ok_pollreq", 8'(poll_req), 8'd0);
    chk("cr_ok_phymode", 8'(phymode), 8'd3);
    idle(WAIT - 1);
    chk("eq_poll_early", 8'(poll_req), 8'd0);
    idle(1);
    chk("eq_poll_rise", 8'(poll_req), 8'd1);
    ack(1, 1);
    chk("act_phymode", 8'(phymode), 8'd1);
    chk("act_trained", 8'(trained), 8'd1);
    chk("act_busy", 8'(busy), 8'd0);
    chk("act_tries", 8'(tries), 8'd0);

    // retrain from ACTIVE, then exhaust CR retries
    tick(0, 1, 0, 0, 0, 0);
    chk("retrain_trained", 8'(trained), 8'd0);
    chk("retrain_phymode", 8'(phymode), 8'd2);
    chk("retrain_busy", 8'(busy), 8'd1);
    idle(WAIT); ack(0, 0);
    chk("cr_try1", 8'(tries), 8'd1);
    idle(WAIT); ack(0, 0);
    chk("cr_try2", 8'(tries), 8'd2);
    idle(WAIT); ack(0, 0);
    chk("cr_fail_phymode", 8'(phymode), 8'd0);
    chk("cr_fail_failed", 8'(failed), 8'd1);
    chk("cr_fail_busy", 8'(busy), 8'd0);
    idle(3);
    chk("fail_hold", 8'(failed), 8'd1);
    tick(0, 1, 0, 0, 0, 0);
    chk("retry_failed", 8'(failed), 8'd0);
    chk("retry_phymode", 8'(phymode), 8'd2);
    chk("retry_tries", 8'(tries), 8'd0);

    // EQ retries then CR lost
    idle(WAIT); ack(1, 0);
    idle(WAIT); ack(1, 0);
    idle(WAIT); ack(1, 0);
    chk("eq_try2", 8'(tries), 8'd2);
    chk("eq_try2_phymode", 8'(phymode), 8'd3);
    idle(WAIT); ack(0, 1);
    chk("eq_crlost_failed", 8'(failed), 8'd1);
    chk("eq_crlost_tries", 8'(tries), 8'd2);

    // EQ exhausted
    tick(0, 1, 0, 0, 0, 0);
    idle(WAIT); ack(1, 0);
    for (int i = 0; i < EQT; i++) begin
      idle(WAIT); ack(1, 0);
    end
    chk("eq_fail_failed", 8'(failed), 8'd1);
    chk("eq_fail_phymode", 8'(phymode), 8'd0);

    // abort
    tick(0, 1, 0, 0, 0, 0);
    idle(WAIT);
    chk("abort_pre", 8'(poll_req), 8'd1);
    tick(0, 0, 1, 0, 0, 0);
    chk("abort_pollreq", 8'(poll_req), 8'd0);
    chk("abort_phymode", 8'(phymode), 8'd0);
    ack(1, 1);
    chk("late_ack_phymode", 8'(phymode), 8'd0);
    chk("late_ack_flags", 8'({busy, trained, failed}), 8'd0);
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 1, 1, 0, 0, 0);
    chk("stop_start_phymode", 8'(phymode), 8'd0);
    chk("stop_start_busy", 8'(busy), 8'd0);

    // full sequence, retrain, then reset in EQ_WAIT
    tick(0, 1, 0, 0, 0, 0);
    idle(WAIT); ack(1, 0);
    idle(WAIT); ack(1, 1);
    chk("seq2_trained", 8'(trained), 8'd1);
    tick(0, 1, 0, 0, 0, 0);
    idle(WAIT); ack(1, 0);
    idle(2);
    tick(1, 0, 0, 0, 0, 0);
    chk("midrst_phymode", 8'(phymode), 8'd0);
    chk("midrst_flags", 8'({poll_req, busy, trained, failed}), 8'd0);
    chk("midrst_tries", 8'(tries), 8'd0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit r, s, p, a, c, e;
      r = ($urandom_range(499) == 0);
      s = ($urandom_range(39) == 0);
      p = ($urandom_range(79) == 0);
      a = poll_req ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
      c = ($urandom_range(3) != 0);
      e = ($urandom_range(2) != 0);
      tick(r, s, p, a, c, e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/link_train_ctl.md
Name: link_train_ctl

Overview:
- Sequences DisplayPort main-link training by driving the 2-bit phymode select of the PHY output mux.
- phymode encodings: 0 idle, 1 scrambled video, 2 TPS1 (D10.2), 3 TPS2.
- Sits between the AUX-channel poller, which reads sink CR/EQ status from DPCD, and the PHY.
- Handles clock-recovery and channel-equalisation phases with per-poll wait timers, retry limits, abort and retrain.

Parameters:
WAIT_CYC, 1000, dpclk cycles of pattern transmission before each status poll (>=1)
CR_TRIES, 5, max failed CR polls before FAIL (1..7)
EQ_TRIES, 5, max failed EQ polls before FAIL (1..7)

Ports:
dpclk  in  1  link clock
reset  in  1  synchronous active-high reset
start  in  1  pulse: begin/restart training
stop  in  1  pulse: abort, return to idle
poll_req  out  1  request AUX status read
poll_ack  in  1  single-cycle: poll complete, poll_cr/poll_eq valid
poll_cr  in  1  sink reports clock recovery done (all lanes)
poll_eq  in  1  sink reports EQ+symbol lock+interlane align done
phymode  out  2  to PHY mode select
busy  out  1  training in progress
trained  out  1  link active
failed  out  1  training failed (sticky)
tries  out  3  failed polls in current phase

Behaviour:
- One clock domain, dpclk; reset is synchronous and active-high.
- All outputs are registered and reflect the state entered at the current edge.
- Reset:
  - state IDLE, phymode 0, poll_req 0, busy 0, trained 0, failed 0, tries 0, timer 0.
  - Reset mid-training aborts immediately with the same values.
- States and phymode/flags:
  - IDLE: phymode 0, all flags 0.
  - CR_WAIT, CR_POLL: phymode 2, busy 1.
  - EQ_WAIT, EQ_POLL: phymode 3, busy 1.
  - ACTIVE: phymode 1, trained 1.
  - FAIL: phymode 0, failed 1.
- Priority per edge: reset > stop > start > poll_ack > timer.
- stop in any state: next state IDLE; poll_req drops on the same edge; tries cleared.
- start in any state other than IDLE-with-stop:
  - next state CR_WAIT; timer = WAIT_CYC-1; tries 0; failed cleared.
  - This gives retrain from ACTIVE and retry from FAIL.
  - start during an outstanding poll cancels that poll; a poll_ack arriving later is ignored unless in CR_POLL/EQ_POLL.
- CR_WAIT/EQ_WAIT: timer decrements each cycle. At timer==0, move to the matching POLL state with poll_req=1.
  - Exactly WAIT_CYC cycles of the pattern precede poll_req rising.
- CR_POLL: poll_req held 1 until poll_ack is sampled; it deasserts on that same edge.
  - poll_cr=1 -> EQ_WAIT, timer reload, tries 0.
  - poll_cr=0 -> tries+1; if tries+1==CR_TRIES -> FAIL, else CR_WAIT with timer reload.
- EQ_POLL: same handshake.
  - poll_cr=0 -> FAIL (CR lost), tries unchanged.
  - poll_cr=1, poll_eq=1 -> ACTIVE, tries 0.
  - poll_cr=1, poll_eq=0 -> tries+1; if tries+1==EQ_TRIES -> FAIL, else EQ_WAIT with reload.
- poll_ack outside POLL states is ignored; poll_cr/poll_eq are don't-care without poll_ack.
- ACTIVE and FAIL hold indefinitely until start/stop.
- The timer is clog2(WAIT_CYC)-bit and never wraps: reloaded on each WAIT entry, frozen at 0 outside WAIT states.
- No other outputs change while waiting for poll_ack; there is no ack timeout (the AUX block owns that).

Test Plan:
- Params WAIT_CYC=4, CR_TRIES=3, EQ_TRIES=3. Reset held 2 cycles -> phymode 0, all flags 0, poll_req 0.
- Happy path: start pulse -> phymode 2 next cycle; poll_req rises exactly 4 cycles later. Ack with cr=1 -> poll_req 0, phymode 3; 4 cycles later poll_req. Ack with cr=1,eq=1 -> phymode 1, trained 1, busy 0, tries 0.
- CR retries: three acks with cr=0 -> tries goes 1, 2, then FAIL with phymode 0, failed 1, busy 0. Next start -> failed 0, phymode 2, tries 0.
- EQ behaviour:
  - eq=0 twice -> tries 2, phymode stays 3.
  - Then an ack with cr=0 -> FAIL immediately, tries stays 2.
  - Separate run with eq=0 three times -> FAIL.
- Abort: stop while poll_req=1 -> IDLE, poll_req 0 next edge. A late poll_ack (cr=1,eq=1) in IDLE -> no change. stop and start on the same cycle -> IDLE.
- Retrain: in ACTIVE, assert start -> trained 0, phymode 2, busy 1 next cycle. A full sequence completes again; reset asserted mid-EQ_WAIT -> all reset values next edge.
